// File: rtl/htfab_asicle2.sv
// htfab_asicle2 -- single-player Wordle-style game engine ("asicle").
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   ena          : command enable; when low every command is ignored
//   ui_in[4:0]   : letter code (0=A .. 25=Z)
//   ui_in[5]     : command strobe (one command per rising edge)
//   ui_in[7:6]   : 00 letter, 01 backspace, 10 submit, 11 load-secret letter
//   uo_out       : scores of positions 0..3, 2 bits each, pos0 in [1:0]
//   uio_in       : unused
//   uio_out      : [1:0] pos4 score, [2] win, [3] lose, [6:4] guesses used, [7] busy
//   uio_oe       : all outputs enabled
// Score codes: 00 empty, 01 absent, 10 present elsewhere, 11 correct.
module htfab_asicle2 #(
  parameter logic [24:0] DEFAULT_SECRET = {5'd18, 5'd15, 5'd8, 5'd7, 5'd2},
  parameter int unsigned MAX_GUESSES    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GREEN = 3'd1;
  localparam logic [2:0] S_Y0    = 3'd2;
  localparam logic [2:0] S_Y4    = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [2:0] MAX_G = 3'(MAX_GUESSES);

  logic [7:0] ui_s1_q, ui_s2_q;
  logic       stb_prev_q;
  logic [2:0] state_q;
  logic [4:0] buf_q [5];
  logic [4:0] sec_q [5];
  logic [2:0] len_q;
  logic [2:0] ptr_q;
  logic [1:0] sc_q  [5];
  logic [2:0] cnt_q [26];
  logic [2:0] cnt_d [26];
  logic [9:0] score_q;
  logic       win_q, lose_q;
  logic [2:0] count_q;

  logic       busy;
  logic       cmd_go;
  logic [1:0] cmd;
  logic [4:0] code;
  logic       code_ok;
  logic [4:0] green;
  logic [2:0] ypos;
  logic       unused_ok;

  assign unused_ok = ^uio_in;

  assign busy    = (state_q != S_IDLE);
  assign cmd     = ui_s2_q[7:6];
  assign code    = ui_s2_q[4:0];
  assign code_ok = (code <= 5'd25);
  assign cmd_go  = ui_s2_q[5] & ~stb_prev_q & ena & ~busy;
  assign ypos    = state_q - S_Y0;

  always_comb begin
    for (int unsigned j = 0; j < 5; j++) begin
      green[j] = (buf_q[j] == sec_q[j]);
    end
  end

  // Remaining secret-letter counts, excluding positions already matched exactly.
  always_comb begin
    for (int unsigned l = 0; l < 26; l++) begin
      cnt_d[l] = '0;
    end
    for (int unsigned j = 0; j < 5; j++) begin
      if (!green[j]) begin
        cnt_d[sec_q[j]] = cnt_d[sec_q[j]] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_s1_q    <= '0;
      ui_s2_q    <= '0;
      stb_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      len_q      <= '0;
      ptr_q      <= '0;
      score_q    <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      count_q    <= '0;
      for (int unsigned j = 0; j < 5; j++) begin
        buf_q[j] <= '0;
        sec_q[j] <= DEFAULT_SECRET[j*5 +: 5];
        sc_q[j]  <= '0;
      end
      for (int unsigned l = 0; l < 26; l++) begin
        cnt_q[l] <= '0;
      end
    end else begin
      ui_s1_q    <= ui_in;
      ui_s2_q    <= ui_s1_q;
      stb_prev_q <= ui_s2_q[5];

      case (state_q)
        S_IDLE: begin
          if (cmd_go) begin
            case (cmd)
              2'b00: begin
                if (code_ok && len_q < 3'd5 && !win_q && !lose_q) begin
                  buf_q[len_q] <= code;
                  len_q        <= len_q + 3'd1;
                end
              end
              2'b01: begin
                if (len_q != 3'd0) len_q <= len_q - 3'd1;
              end
              2'b10: begin
                if (len_q == 3'd5 && !win_q && !lose_q) state_q <= S_GREEN;
              end
              default: begin
                if (code_ok) begin
                  sec_q[ptr_q] <= code;
                  ptr_q        <= (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
                  score_q      <= '0;
                  win_q        <= 1'b0;
                  lose_q       <= 1'b0;
                  count_q      <= '0;
                  len_q        <= '0;
                end
              end
            endcase
          end
        end
        S_GREEN: begin
          for (int unsigned j = 0; j < 5; j++) begin
            sc_q[j] <= green[j] ? 2'b11 : 2'b00;
          end
          for (int unsigned l = 0; l < 26; l++) begin
            cnt_q[l] <= cnt_d[l];
          end
          state_q <= S_Y0;
        end
        S_DONE: begin
          score_q <= {sc_q[4], sc_q[3], sc_q[2], sc_q[1], sc_q[0]};
          count_q <= count_q + 3'd1;
          win_q   <= &green;
          lose_q  <= ~(&green) && (count_q + 3'd1 == MAX_G);
          len_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          // Y0..Y4: left-to-right so duplicates only consume unmatched secret letters.
          if (sc_q[ypos] != 2'b11) begin
            if (cnt_q[buf_q[ypos]] != 3'd0) begin
              sc_q[ypos]          <= 2'b10;
              cnt_q[buf_q[ypos]]  <= cnt_q[buf_q[ypos]] - 3'd1;
            end else begin
              sc_q[ypos] <= 2'b01;
            end
          end
          state_q <= (state_q == S_Y4) ? S_DONE : state_q + 3'd1;
        end
      endcase
    end
  end

  assign uo_out  = score_q[7:0];
  assign uio_out = {busy, count_q, lose_q, win_q, score_q[9:8]};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_htfab_asicle2.sv
// Directed bench for htfab_asicle2: drives strobed commands through the
// synchronizer and checks scores / status against hand-computed values.
module tb_htfab_asicle2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_in = '0;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [24:0] W_CHIPS = {5'd18, 5'd15, 5'd8, 5'd7, 5'd2};
  localparam logic [24:0] W_SPICY = {5'd24, 5'd2, 5'd8, 5'd15, 5'd18};
  localparam logic [24:0] W_AAAAA = '0;

  htfab_asicle2 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe rises at a negedge, held 4 cycles, then 3 idle cycles:
  // returns just after the 7th posedge (command executed on the 3rd).
  task automatic send(input logic [1:0] cmd, input logic [4:0] code);
    @(negedge clk);
    ui_in = {cmd, 1'b1, code};
    repeat (4) @(negedge clk);
    ui_in[5] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) send(2'b00, w[i*5 +: 5]);
  endtask

  task automatic load_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) send(2'b11, w[i*5 +: 5]);
  endtask

  // Submit, then wait until 8 cycles after execution.
  task automatic submit_wait();
    send(2'b10, 5'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    ui_in = '0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_uo"}, uo_out, 8'h00);
    check({tag, "_rst_uio"}, uio_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset("r0");
    check("uio_oe", uio_oe, 8'hFF);

    // Correct guess on first try.
    type_word(W_CHIPS);
    send(2'b10, 5'd0);
    check("chips_busy", {7'b0, uio_out[7]}, 8'h01);
    repeat (4) @(negedge clk);
    check("chips_uo", uo_out, 8'hFF);
    check("chips_uio", uio_out, 8'h17);
    // Letters and submits are ignored once the game is won.
    type_word(W_SPICY);
    submit_wait();
    check("after_win_uio", uio_out, 8'h17);

    // Backspace on empty, then SPICY; an extra submit while busy is ignored.
    do_reset("r1");
    send(2'b01, 5'd0);
    type_word(W_SPICY);
    send(2'b10, 5'd0);
    send(2'b10, 5'd0);
    repeat (4) @(negedge clk);
    check("spicy_uo", uo_out, 8'hBA);
    check("spicy_uio", uio_out, 8'h11);
    // Six letters: only the first five kept.
    type_word(W_SPICY);
    send(2'b00, 5'd25);
    submit_wait();
    check("six_uo", uo_out, 8'hBA);
    check("six_uio", uio_out, 8'h21);

    // Short submit, invalid code, ena gating, then SSSSS.
    do_reset("r2");
    for (int i = 0; i < 4; i++) send(2'b00, 5'd18);
    submit_wait();
    check("short_uio", uio_out, 8'h00);
    send(2'b00, 5'd27);
    send(2'b00, 5'd18);
    ena = 1'b0;
    submit_wait();
    check("ena0_uio", uio_out, 8'h00);
    ena = 1'b1;
    submit_wait();
    check("sssss_uo", uo_out, 8'h55);
    check("sssss_uio", uio_out, 8'h13);

    // Six wrong guesses lose the game.
    do_reset("r3");
    for (int k = 1; k <= 5; k++) begin
      type_word(W_AAAAA);
      submit_wait();
      check("aaaaa_uio", uio_out, 8'((k << 4) | 1));
    end
    type_word(W_AAAAA);
    submit_wait();
    check("lose_uo", uo_out, 8'h55);
    check("lose_uio", uio_out, 8'h69);
    type_word(W_AAAAA);
    submit_wait();
    check("lose7_uio", uio_out, 8'h69);

    // Load-secret AAAAA clears state even after a loss.
    load_word(W_AAAAA);
    check("load_uo", uo_out, 8'h00);
    check("load_uio", uio_out, 8'h00);
    type_word(W_AAAAA);
    submit_wait();
    check("newsec_uo", uo_out, 8'hFF);
    check("newsec_uio", uio_out, 8'h17);

    // Strobe held 20 cycles enters exactly one letter.
    load_word(W_CHIPS);
    check("reload_uio", uio_out, 8'h00);
    @(negedge clk);
    ui_in = {2'b00, 1'b1, 5'd2};
    repeat (20) @(negedge clk);
    ui_in[5] = 1'b0;
    repeat (3) @(negedge clk);
    send(2'b00, 5'd7);
    send(2'b00, 5'd8);
    send(2'b00, 5'd15);
    send(2'b00, 5'd18);
    submit_wait();
    check("held_uo", uo_out, 8'hFF);
    check("held_uio", uio_out, 8'h17);

    // Reset mid-evaluation aborts immediately.
    do_reset("r4");
    type_word(W_SPICY);
    send(2'b10, 5'd0);
    check("mid_busy", {7'b0, uio_out[7]}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uio", uio_out, 8'h00);
    check("mid_rst_uo", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_after_uio", uio_out, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
